// File: rtl/apb_read_master_if.sv
// Purpose: bundles the AHB-side request/response and APB-side bus signals of the read bridge.
// Latency: none (wires only).
// Backpressure: carried by PREADY (APB wait states) and o_HREADY (completion pulse).
//
// Ports (signals):
//   i_start_read_transfer, i_HADDR, i_HSIZE  - request from the AHB stage
//   o_HREADY, o_HRDATA, o_HRESP              - completion back to the AHB stage
//   PADDR, PSEL, PENABLE, PWRITE             - APB request
//   PRDATA, PREADY, PSLVERR                  - APB response
// Modports: master = bridge view, slave = environment (AHB stage + APB slave) view.
interface apb_read_master_if #(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32,
  parameter int APB_DW = 8
);
  logic              i_start_read_transfer;
  logic [AHB_AW-1:0] i_HADDR;
  logic [2:0]        i_HSIZE;
  logic              o_HREADY;
  logic [AHB_DW-1:0] o_HRDATA;
  logic              o_HRESP;
  logic [AHB_AW-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  i_start_read_transfer, i_HADDR, i_HSIZE, PRDATA, PREADY, PSLVERR,
    output o_HREADY, o_HRDATA, o_HRESP, PADDR, PSEL, PENABLE, PWRITE
  );

  modport slave (
    output i_start_read_transfer, i_HADDR, i_HSIZE, PRDATA, PREADY, PSLVERR,
    input  o_HREADY, o_HRDATA, o_HRESP, PADDR, PSEL, PENABLE, PWRITE
  );
endinterface

// File: rtl/apb_read_master.sv
// Purpose: AHB-to-APB read bridge; splits one AHB read into APB_DW-wide APB beats and assembles the result.
// Latency: 2N+1 cycles from request acceptance to the o_HREADY pulse for N beats with no wait states.
// Backpressure: PREADY=0 stretches ACCESS indefinitely; new requests are only taken in IDLE.
//
// Ports:
//   HCLK    - bridge clock, rising edge
//   HRESET  - synchronous active-high reset, overrides everything
//   bus     - apb_read_master_if.master (AHB request/response + APB master signals)
module apb_read_master #(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32,
  parameter int APB_DW = 8
) (
  input logic              HCLK,
  input logic              HRESET,
  apb_read_master_if.master bus
);

  localparam int BPB  = APB_DW / 8;           // bytes per APB beat
  localparam int MAXB = AHB_DW / APB_DW;      // most beats a transfer can need
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [2:0]        MAX_SIZE   = 3'($clog2(AHB_DW / 8));
  localparam logic [2:0]        BPB_LOG    = 3'($clog2(BPB));
  localparam logic [AHB_AW-1:0] ALIGN_MASK = ~AHB_AW'(BPB - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [AHB_AW-1:0] addr_q,  addr_d;
  logic [CW-1:0]     beat_q,  beat_d;
  logic [CW-1:0]     last_q,  last_d;
  logic              err_q,   err_d;
  logic [AHB_DW-1:0] rdata_q, rdata_d;

  // HSIZE is only ever needed as "index of the last beat", so that is what
  // gets latched instead of the raw size field.
  logic [2:0]    size_sat;
  logic [CW-1:0] last_beat;

  always_comb begin
    size_sat = (bus.i_HSIZE > MAX_SIZE) ? MAX_SIZE : bus.i_HSIZE;
    if (size_sat <= BPB_LOG) begin
      last_beat = '0;
    end else begin
      last_beat = CW'((32'd1 << (size_sat - BPB_LOG)) - 32'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    last_d  = last_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start_read_transfer) begin
          addr_d  = bus.i_HADDR;
          last_d  = last_beat;
          beat_d  = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          // Data is captured even on an error beat; the error flag tells the
          // AHB stage not to trust it.
          rdata_d[int'(beat_q) * APB_DW +: APB_DW] = bus.PRDATA;
          if (bus.PSLVERR) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (beat_q == last_q) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + CW'(1);
            state_d = S_SETUP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are pure functions of registered state, so PADDR stays put
  // through any number of wait states.
  assign bus.PADDR    = (addr_q & ALIGN_MASK) + AHB_AW'(int'(beat_q) * BPB);
  assign bus.PSEL     = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.PENABLE  = (state_q == S_ACCESS);
  assign bus.PWRITE   = 1'b0;
  assign bus.o_HREADY = (state_q == S_DONE);
  assign bus.o_HRESP  = (state_q == S_DONE) && err_q;
  assign bus.o_HRDATA = rdata_q;

endmodule

// File: tb/tb_apb_read_master.sv
// Purpose: self-checking bench for apb_read_master (AHB_DW=32, APB_DW=8).
// Latency: n/a.
// Backpressure: bench acts as APB slave and inserts wait states / errors on chosen beats.
module tb_apb_read_master;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;
  localparam int APB_DW = 8;
  localparam int BPB    = APB_DW / 8;

  logic HCLK;
  logic HRESET;

  apb_read_master_if #(.AHB_AW(AHB_AW), .AHB_DW(AHB_DW), .APB_DW(APB_DW)) bus ();

  apb_read_master #(.AHB_AW(AHB_AW), .AHB_DW(AHB_DW), .APB_DW(APB_DW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    int          wait_beat;
    int          wait_n;
    logic [31:0] data;       // byte k is returned on beat k
    int          err_beat;   // -1: no error
    logic [31:0] exp_pa0;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    int          exp_lat;
    int          exp_beats;
  } vec_t;

  vec_t vecs[8];

  // Reference model: what a transaction should produce, from the bridge's rules.
  task automatic model(input logic [31:0] addr, input logic [2:0] size, input int wait_beat,
                       input int wait_n, input logic [31:0] data, input int err_beat,
                       output logic [31:0] pa0, output logic [31:0] rdata, output logic resp,
                       output int lat, output int beats);
    int s;
    int nb;
    s  = (int'(size) > 2) ? 2 : int'(size);
    nb = (1 << s) / BPB;
    if (nb < 1) nb = 1;
    resp  = (err_beat >= 0) && (err_beat < nb);
    beats = resp ? err_beat + 1 : nb;
    rdata = '0;
    for (int k = 0; k < beats; k++) rdata[k*APB_DW +: APB_DW] = data[k*APB_DW +: APB_DW];
    lat = 2 * beats + 1 + ((wait_beat < beats) ? wait_n : 0);
    pa0 = addr & ~32'(BPB - 1);
  endtask

  // Drives one request and plays APB slave until o_HREADY (or reset injection).
  // Called at #1 after a clock edge. Returns at #1 after the edge showing DONE.
  task automatic run_txn(input logic [31:0] addr, input logic [2:0] size, input int wait_beat,
                         input int wait_n, input logic [31:0] data, input int err_beat,
                         input bit hold, input int rst_beat, input logic [31:0] pa0,
                         input int exp_gap, output logic [31:0] rdata, output logic resp,
                         output int lat, output int beats);
    int k;
    int w;
    int cyc;
    int gap;
    int early_rdy;
    bus.i_HADDR = addr;
    bus.i_HSIZE = size;
    bus.i_start_read_transfer = 1'b1;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    gap = 0;
    early_rdy = 0;
    while (!(bus.PSEL && !bus.PENABLE) && gap < 20) begin
      @(posedge HCLK); #1;
      gap++;
      if (bus.o_HREADY) early_rdy++;
    end
    check("accept_gap", 64'(gap), 64'(exp_gap));
    check("hready_before_setup", 64'(early_rdy), 64'd0);
    if (!hold) bus.i_start_read_transfer = 1'b0;
    // Request inputs must have been latched; scramble them.
    bus.i_HADDR = $urandom;
    bus.i_HSIZE = 3'($urandom_range(0, 7));
    cyc = 1;
    k = 0;
    w = 0;
    rdata = '0;
    resp  = 1'b0;
    while (!bus.o_HREADY && cyc < 200) begin
      if (bus.PSEL && !bus.PENABLE) begin
        check("setup_paddr", 64'(bus.PADDR), 64'(pa0 + 32'(k * BPB)));
        bus.PREADY = 1'b0;
      end else if (bus.PSEL && bus.PENABLE) begin
        check("access_paddr", 64'(bus.PADDR), 64'(pa0 + 32'(k * BPB)));
        if (k == rst_beat) begin
          bus.PREADY = 1'b0;
          HRESET = 1'b1;
          @(posedge HCLK); #1;
          HRESET = 1'b0;
          check("rst_psel", 64'(bus.PSEL), 64'd0);
          check("rst_penable", 64'(bus.PENABLE), 64'd0);
          check("rst_hrdata", 64'(bus.o_HRDATA), 64'd0);
          check("rst_hready", 64'(bus.o_HREADY), 64'd0);
          check("rst_paddr", 64'(bus.PADDR), 64'd0);
          lat = cyc;
          beats = k;
          return;
        end
        if (k == wait_beat && w < wait_n) begin
          bus.PREADY = 1'b0;
          w++;
        end else begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = data[k*APB_DW +: APB_DW];
          bus.PSLVERR = (k == err_beat);
          k++;
        end
      end else begin
        check("psel_mid_transfer", 64'(bus.PSEL), 64'd1);
        break;
      end
      @(posedge HCLK); #1;
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      cyc++;
    end
    check("hready_reached", 64'(bus.o_HREADY), 64'd1);
    check("done_psel_penable", 64'({bus.PSEL, bus.PENABLE}), 64'd0);
    rdata = bus.o_HRDATA;
    resp  = bus.o_HRESP;
    lat   = cyc;
    beats = k;
  endtask

  logic [31:0] got_rdata, e_pa0, e_rdata, r_addr, r_data;
  logic        got_resp, e_resp;
  logic [2:0]  r_size;
  int          got_lat, got_beats, e_lat, e_beats, r_wb, r_wn, r_eb, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h103, 3'd0, 0, 0, 32'h000000A5, -1, 32'h103, 32'h000000A5, 1'b0, 3, 1};
    vecs[1] = '{32'h200, 3'd2, 0, 0, 32'h44332211, -1, 32'h200, 32'h44332211, 1'b0, 9, 4};
    vecs[2] = '{32'h300, 3'd1, 0, 3, 32'h0000BEEF, -1, 32'h300, 32'h0000BEEF, 1'b0, 8, 2};
    vecs[3] = '{32'h400, 3'd2, 0, 0, 32'h44332211,  1, 32'h400, 32'h00002211, 1'b1, 5, 2};
    vecs[4] = '{32'h500, 3'd2, 2, 1, 32'hDEADBEEF, -1, 32'h500, 32'hDEADBEEF, 1'b0, 10, 4};
    vecs[5] = '{32'h007, 3'd0, 0, 0, 32'hFFFFFF12, -1, 32'h007, 32'h00000012, 1'b0, 3, 1};
    vecs[6] = '{32'h010, 3'd5, 3, 2, 32'h87654321,  3, 32'h010, 32'h87654321, 1'b1, 11, 4};
    vecs[7] = '{32'h020, 3'd1, 0, 0, 32'h0000CAFE,  0, 32'h020, 32'h000000FE, 1'b1, 3, 1};

    // Reset with a request pending: reset must win.
    HRESET = 1'b1;
    bus.i_start_read_transfer = 1'b1;
    bus.i_HADDR = 32'hFFFF_FFFF;
    bus.i_HSIZE = 3'd2;
    bus.PRDATA  = '0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_psel", 64'(bus.PSEL), 64'd0);
    check("reset_penable", 64'(bus.PENABLE), 64'd0);
    check("reset_pwrite", 64'(bus.PWRITE), 64'd0);
    check("reset_paddr", 64'(bus.PADDR), 64'd0);
    check("reset_hready", 64'(bus.o_HREADY), 64'd0);
    check("reset_hresp", 64'(bus.o_HRESP), 64'd0);
    check("reset_hrdata", 64'(bus.o_HRDATA), 64'd0);
    bus.i_start_read_transfer = 1'b0;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].addr, vecs[i].size, vecs[i].wait_beat, vecs[i].wait_n, vecs[i].data,
              vecs[i].err_beat, 1'b0, -1, vecs[i].exp_pa0, 1,
              got_rdata, got_resp, got_lat, got_beats);
      check($sformatf("vec%0d_rdata", i), 64'(got_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_resp", i), 64'(got_resp), 64'(vecs[i].exp_resp));
      check($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_beats", i), 64'(got_beats), 64'(vecs[i].exp_beats));
      @(posedge HCLK); #1;
      check($sformatf("vec%0d_hready_one_cycle", i), 64'(bus.o_HREADY), 64'd0);
      check($sformatf("vec%0d_hresp_after", i), 64'(bus.o_HRESP), 64'd0);
      check($sformatf("vec%0d_rdata_held", i), 64'(bus.o_HRDATA), 64'(vecs[i].exp_rdata));
    end

    // Reset during ACCESS of beat 2, then a clean transaction.
    run_txn(32'h600, 3'd2, 0, 0, 32'hAABBCCDD, -1, 1'b0, 2, 32'h600, 1,
            got_rdata, got_resp, got_lat, got_beats);
    check("rst_beats_before", 64'(got_beats), 64'd2);
    seen = 0;
    repeat (4) begin
      @(posedge HCLK); #1;
      if (bus.o_HREADY || bus.PSEL) seen++;
    end
    check("rst_no_pulse_after", 64'(seen), 64'd0);
    run_txn(32'h700, 3'd2, 0, 0, 32'h0C0B0A09, -1, 1'b0, -1, 32'h700, 1,
            got_rdata, got_resp, got_lat, got_beats);
    check("post_rst_rdata", 64'(got_rdata), 64'h0C0B0A09);
    check("post_rst_latency", 64'(got_lat), 64'd9);
    @(posedge HCLK); #1;

    // Back-to-back: request held high across DONE.
    run_txn(32'h800, 3'd1, 0, 0, 32'h00005A5A, -1, 1'b1, -1, 32'h800, 1,
            got_rdata, got_resp, got_lat, got_beats);
    check("b2b_first_rdata", 64'(got_rdata), 64'h5A5A);
    check("b2b_first_latency", 64'(got_lat), 64'd5);
    run_txn(32'h900, 3'd0, 0, 0, 32'h00000077, -1, 1'b1, -1, 32'h900, 2,
            got_rdata, got_resp, got_lat, got_beats);
    bus.i_start_read_transfer = 1'b0;
    check("b2b_second_rdata", 64'(got_rdata), 64'h77);
    check("b2b_second_latency", 64'(got_lat), 64'd3);
    seen = 0;
    repeat (3) begin
      @(posedge HCLK); #1;
      if (bus.o_HREADY || bus.PSEL) seen++;
    end
    check("b2b_no_extra_txn", 64'(seen), 64'd0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_addr = $urandom;
      r_size = 3'($urandom_range(0, 4));
      r_wb   = $urandom_range(0, 3);
      r_wn   = $urandom_range(0, 3);
      r_data = $urandom;
      r_eb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      model(r_addr, r_size, r_wb, r_wn, r_data, r_eb, e_pa0, e_rdata, e_resp, e_lat, e_beats);
      run_txn(r_addr, r_size, r_wb, r_wn, r_data, r_eb, 1'b0, -1, e_pa0, 1,
              got_rdata, got_resp, got_lat, got_beats);
      check($sformatf("rand%0d_rdata", i), 64'(got_rdata), 64'(e_rdata));
      check($sformatf("rand%0d_resp", i), 64'(got_resp), 64'(e_resp));
      check($sformatf("rand%0d_latency", i), 64'(got_lat), 64'(e_lat));
      check($sformatf("rand%0d_beats", i), 64'(got_beats), 64'(e_beats));
      @(posedge HCLK); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
